wrr_burst_arbiter: RTL and testbench

- Weighted round-robin arbiter that shares one downstream beat-based port among NUM_REQ requesters.
- A winner holds a registered grant for a burst of beats. The burst ends on `req_last`, on quota exhaustion, or when the request is withdrawn.
- Priority then rotates so the previous owner becomes lowest priority.
- Sits between requester masters and a shared datapath or resource; the datapath steers on `gnt_id`.

---
 rtl/wrr_burst_arbiter.sv | 139 +++++++++++++
 tb/tb_wrr_burst_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin burst arbiter.
// One requester at a time owns the shared beat port for a burst of up to
// max(weight,1) beats. The burst ends on req_last, on quota exhaustion or when
// the owner withdraws its request. Priority then rotates past the old owner.
//
//   state | meaning
//   IDLE  | no owner; arbitrate over req every cycle
//   GRANT | owner gnt_id holds the port; credit = beats still allowed
module wrr_burst_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WEIGHT_W = 4,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [NUM_REQ*WEIGHT_W-1:0] weight,
    input  logic                        ready,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        gnt_valid,
    output logic [ID_W-1:0]             gnt_id,
    output logic                        beat
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [NUM_REQ-1:0]    gnt_nxt;
    logic                  gnt_valid_nxt;
    logic [ID_W-1:0]       gnt_id_nxt;
    logic [ID_W-1:0]       ptr;
    logic [ID_W-1:0]       ptr_nxt;
    logic [WEIGHT_W-1:0]   credit;
    logic [WEIGHT_W-1:0]   credit_nxt;
    logic [WEIGHT_W-1:0]   quota [NUM_REQ];

    logic [NUM_REQ-1:0]    arb_req;
    logic [ID_W-1:0]       arb_base;
    logic [ID_W-1:0]       arb_pos;
    logic                  arb_found;
    logic [ID_W-1:0]       arb_idx;
    logic                  release_now;
    logic                  load;

    // A zero weight still grants one beat so a requester can never starve itself.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_quota
        assign quota[i] = (weight[i*WEIGHT_W +: WEIGHT_W] == '0) ?
                          WEIGHT_W'(1) : weight[i*WEIGHT_W +: WEIGHT_W];
    end

    assign beat = gnt_valid & req[gnt_id] & ready;

    // Rotating priority scan: start just after the last owner; in GRANT the
    // current owner is masked so a release hands over without an idle cycle.
    always_comb begin
        arb_req   = (state == GRANT) ? (req & ~gnt) : req;
        arb_base  = (state == GRANT) ? gnt_id : ptr;
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_pos   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            arb_pos = ID_W'((int'(arb_base) + k) % NUM_REQ);
            if (!arb_found && arb_req[arb_pos]) begin
                arb_found = 1'b1;
                arb_idx   = arb_pos;
            end
        end
    end

    // Next-state and next-grant decode; withdrawal outranks any beat.
    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        gnt_valid_nxt = gnt_valid;
        gnt_id_nxt    = gnt_id;
        ptr_nxt       = ptr;
        credit_nxt    = credit;
        release_now   = 1'b0;

        case (state)
            IDLE: begin
                release_now = 1'b0;
            end
            GRANT: begin
                if (!req[gnt_id] ||
                    (beat && (req_last[gnt_id] || credit == WEIGHT_W'(1)))) begin
                    release_now = 1'b1;
                    ptr_nxt     = gnt_id;
                end else if (beat) begin
                    credit_nxt = credit - WEIGHT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        load = (state == IDLE) || release_now;
        if (load) begin
            if (arb_found) begin
                state_nxt     = GRANT;
                gnt_nxt       = NUM_REQ'(1) << arb_idx;
                gnt_valid_nxt = 1'b1;
                gnt_id_nxt    = arb_idx;
                credit_nxt    = quota[arb_idx];
            end else begin
                state_nxt     = IDLE;
                gnt_nxt       = '0;
                gnt_valid_nxt = 1'b0;
                gnt_id_nxt    = '0;
            end
        end
    end

    // State, grant, credit and rotation pointer registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            credit    <= '0;
            ptr       <= ID_W'(NUM_REQ - 1);
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            gnt_valid <= gnt_valid_nxt;
            gnt_id    <= gnt_id_nxt;
            credit    <= credit_nxt;
            ptr       <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Bench for wrr_burst_arbiter: directed scenarios with literal expectations,
// a burst-level reference model compared every cycle, and a random soak.
module tb_wrr_burst_arbiter;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_b = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   req_last = '0;
    logic [N*W-1:0] weight = '0;
    logic           ready = 1'b0;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           beat;

    int checks = 0;
    int errors = 0;

    wrr_burst_arbiter #(.NUM_REQ(N), .WEIGHT_W(W)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .req       (req),
        .req_last  (req_last),
        .weight    (weight),
        .ready     (ready),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .beat      (beat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int i, input int v);
        weight[i*W +: W] = W'(v);
    endtask

    // ---------------- reference model (burst level) ----------------
    int m_owner = -1;   // -1: nobody owns the port
    int m_left  = 0;    // beats the owner may still move in this burst
    int m_last  = N-1;  // previous owner, lowest priority next time

    function automatic int quota_of(input int i);
        int q;
        q = int'(weight[i*W +: W]);
        return (q == 0) ? 1 : q;
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int after);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (after + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_owner = -1;
            m_left  = 0;
            m_last  = N-1;
        end else begin
            logic [N-1:0] others;
            int o;
            bit xfer;
            bit done;
            if (m_owner < 0) begin
                o = pick(req, m_last);
                if (o >= 0) begin
                    m_owner = o;
                    m_left  = quota_of(o);
                end
            end else begin
                o    = m_owner;
                xfer = req[o] && ready;
                done = !req[o] || (xfer && (req_last[o] || m_left == 1));
                if (xfer) m_left--;
                if (done) begin
                    m_last    = o;
                    others    = req;
                    others[o] = 1'b0;
                    m_owner   = pick(others, o);
                    if (m_owner >= 0) m_left = quota_of(m_owner);
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_b) begin
            logic [N-1:0] eg;
            eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
            chk("model_gnt", int'(gnt), int'(eg));
            chk("model_gnt_valid", int'(gnt_valid), (m_owner >= 0) ? 1 : 0);
            chk("model_gnt_id", int'(gnt_id), (m_owner < 0) ? 0 : m_owner);
            chk("model_beat", int'(beat),
                (m_owner >= 0 && req[m_owner] && ready) ? 1 : 0);
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int exp_a[10] = '{1, 1, 2, 2, 4, 4, 8, 8, 1, 1};
        int exp_b[8]  = '{2, 2, 2, 0, 2, 2, 2, 0};
        int exp_d[4]  = '{4, 4, 4, 8};
        int exp_e[4]  = '{2, 2, 1, 0};
        int beat_e[4] = '{1, 0, 1, 0};
        int nbeats;

        // Reset values
        #2;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_gnt_valid", int'(gnt_valid), 0);
        chk("rst_gnt_id", int'(gnt_id), 0);
        chk("rst_beat", int'(beat), 0);

        // A: all requesting, weight 2 each
        for (int i = 0; i < N; i++) set_w(i, 2);
        ready = 1'b1;
        tick();
        rst_b = 1'b1;
        req   = 4'b1111;
        @(negedge clk);
        chk("a_latency_gnt", int'(gnt), 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            chk("a_gnt_seq", int'(gnt), exp_a[k]);
            chk("a_beat", int'(beat), 1);
        end
        tick(); req = '0;
        tick();

        // B: lone requester 1, weight 3, regranted after one idle cycle
        tick();
        req = 4'b0010;
        set_w(1, 3);
        @(negedge clk);
        chk("b_latency_gnt", int'(gnt), 0);
        nbeats = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            @(negedge clk);
            chk("b_gnt_seq", int'(gnt), exp_b[k]);
            nbeats += int'(beat);
        end
        chk("b_beats", nbeats, 6);
        tick(); req = '0;
        tick();

        // C: owner 0, weight 4, ready toggling
        tick();
        req   = 4'b0001;
        ready = 1'b0;
        set_w(0, 4);
        @(negedge clk);
        nbeats = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            ready = (k % 2 == 0);
            if (k == 7) req = '0;
            @(negedge clk);
            chk("c_gnt_hold", int'(gnt), (k < 7) ? 1 : 0);
            nbeats += int'(beat);
        end
        chk("c_beats", nbeats, 4);

        // D: owner 2, weight 8, req_last on its 3rd beat hands over to 3
        tick();
        req   = 4'b1100;
        ready = 1'b1;
        set_w(2, 8);
        set_w(3, 2);
        @(negedge clk);
        chk("d_latency_gnt", int'(gnt), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 2) req_last = 4'b0100;
            if (k == 3) begin
                req_last = '0;
                req      = '0;
            end
            @(negedge clk);
            chk("d_gnt_seq", int'(gnt), exp_d[k]);
        end
        tick();

        // E: owner 1 withdraws after one beat, requester 0 with weight 0
        tick();
        req = 4'b0010;
        set_w(1, 4);
        set_w(0, 0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) req = 4'b0011;
            if (k == 1) req = 4'b0001;
            if (k == 3) req = '0;
            @(negedge clk);
            chk("e_gnt_seq", int'(gnt), exp_e[k]);
            chk("e_beat_seq", int'(beat), beat_e[k]);
        end
        tick();

        // F: asynchronous reset mid-burst, then restart from requester 0
        tick();
        req = 4'b1111;
        for (int i = 0; i < N; i++) set_w(i, 4);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("f_pre_rst_gnt", int'(gnt), 2);
        tick();
        #2;
        rst_b = 1'b0;
        #1;
        chk("f_async_gnt", int'(gnt), 0);
        chk("f_async_gnt_valid", int'(gnt_valid), 0);
        chk("f_async_gnt_id", int'(gnt_id), 0);
        req = 4'b1010;
        tick();
        rst_b = 1'b1;
        @(negedge clk);
        chk("f_post_rst_idle", int'(gnt), 0);
        tick();
        @(negedge clk);
        chk("f_post_rst_gnt", int'(gnt), 2);
        chk("f_post_rst_id", int'(gnt_id), 1);
        tick(); req = '0;
        tick();
        tick();

        // G: maximum quota burst of 15 beats
        req = 4'b0100;
        set_w(2, 15);
        @(negedge clk);
        nbeats = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k == 15) req = '0;
            @(negedge clk);
            chk("g_gnt_hold", int'(gnt), (k < 15) ? 4 : 0);
            nbeats += int'(beat);
        end
        chk("g_beats", nbeats, 15);

        // Random soak, checked by the model only
        for (int k = 0; k < 400; k++) begin
            tick();
            req      = N'($urandom);
            req_last = N'($urandom & $urandom & $urandom);
            ready    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) weight = (N*W)'($urandom);
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
